// File: rtl/smp_pkg.sv
// Shared constants and FSM encoding for the SMP scheduler slice.
package smp_pkg;

  localparam int unsigned KEY_W      = 56;
  localparam int unsigned CHX_W      = 8;
  localparam int unsigned RPT_W      = 4;
  localparam int unsigned CNT_W      = 9;
  localparam int unsigned TMO_W_DEF  = 20;
  localparam int unsigned RESP_W_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_GO    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } smp_state_e;

endpackage

// File: rtl/smp_rr_arb.sv
// Two-way round-robin arbiter; owns the last-grant pointer (index of last winner).
module smp_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (enable && grant != '0)
      last <= grant[1];
  end

endmodule

// File: rtl/smp_sched.sv
// Scheduler that arbitrates two requesters onto one SMP core and returns its response.
module smp_sched
  import smp_pkg::*;
#(
  parameter int unsigned TMO_W  = TMO_W_DEF,
  parameter int unsigned RESP_W = RESP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  i_key1,
  input  logic [RPT_W-1:0]  i_rpt,
  input  logic [1:0]        i_req,
  input  logic [KEY_W-1:0]  i_seed0,
  input  logic [KEY_W-1:0]  i_seed1,
  input  logic [CHX_W-1:0]  i_chx0,
  input  logic [CHX_W-1:0]  i_chx1,
  output logic [1:0]        o_ack,
  output logic [RESP_W-1:0] o_resp,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_core_go,
  output logic [KEY_W-1:0]  o_core_key1,
  output logic [KEY_W-1:0]  o_core_seed,
  output logic [CHX_W-1:0]  o_core_chx,
  output logic [RPT_W-1:0]  o_core_rpt,
  input  logic              i_core_q,
  input  logic              i_core_valid,
  input  logic              i_core_done
);

  // Watchdog trips on the edge where it would reach all-ones, so go is held
  // for exactly 2^TMO_W-1 GO cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  smp_state_e        state;
  logic [1:0]        grant;
  logic [1:0]        grant_q;
  logic [CNT_W-1:0]  strb_cnt;
  logic [CNT_W-1:0]  strb_cnt_nxt;
  logic [TMO_W-1:0]  wdog;
  logic [RESP_W-1:0] resp_nxt;
  logic [KEY_W-1:0]  sel_seed;
  logic [CHX_W-1:0]  sel_chx;

  smp_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (i_req),
    .enable (state == ST_ARB),
    .grant  (grant)
  );

  always_comb begin
    sel_seed     = grant[1] ? i_seed1 : i_seed0;
    sel_chx      = grant[1] ? i_chx1  : i_chx0;
    strb_cnt_nxt = strb_cnt + {{(CNT_W-1){1'b0}}, i_core_valid};
    resp_nxt     = i_core_valid ? {o_resp[RESP_W-2:0], i_core_q} : o_resp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant_q     <= '0;
      strb_cnt    <= '0;
      wdog        <= '0;
      o_ack       <= '0;
      o_resp      <= '0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      o_core_go   <= 1'b0;
      o_core_key1 <= '0;
      o_core_seed <= '0;
      o_core_chx  <= '0;
      o_core_rpt  <= '0;
    end else begin
      o_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (i_req != '0 && !i_core_done) begin
            state  <= ST_ARB;
            o_busy <= 1'b1;
          end
        end

        ST_ARB: begin
          if (grant == '0) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            grant_q     <= grant;
            o_core_key1 <= i_key1;
            o_core_rpt  <= i_rpt;
            o_core_seed <= sel_seed;
            o_core_chx  <= sel_chx;
            o_resp      <= '0;
            wdog        <= '0;
            strb_cnt    <= '0;
            if (sel_chx == '0) begin
              o_err <= 1'b1;
              o_ack <= grant;
              state <= ST_RESP;
            end else begin
              o_err     <= 1'b0;
              o_core_go <= 1'b1;
              state     <= ST_GO;
            end
          end
        end

        ST_GO: begin
          o_resp   <= resp_nxt;
          strb_cnt <= strb_cnt_nxt;
          wdog     <= wdog + 1'b1;
          if (i_core_done) begin
            o_core_go <= 1'b0;
            o_err     <= (strb_cnt_nxt != {1'b0, o_core_chx});
            state     <= ST_DRAIN;
          end else if (wdog == TMO_LAST) begin
            o_core_go <= 1'b0;
            o_err     <= 1'b1;
            state     <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (!i_core_done) begin
            o_ack <= grant_q;
            state <= ST_RESP;
          end
        end

        ST_RESP: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          o_busy    <= 1'b0;
          o_core_go <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smp_sched.sv
// Directed-vector bench for smp_sched with a hand-driven core model.
module tb_smp_sched;
  import smp_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [KEY_W-1:0]  i_key1;
  logic [RPT_W-1:0]  i_rpt;
  logic [1:0]        i_req;
  logic [KEY_W-1:0]  i_seed0, i_seed1;
  logic [CHX_W-1:0]  i_chx0, i_chx1;
  logic [1:0]        o_ack;
  logic [63:0]       o_resp;
  logic              o_err, o_busy, o_core_go;
  logic [KEY_W-1:0]  o_core_key1, o_core_seed;
  logic [CHX_W-1:0]  o_core_chx;
  logic [RPT_W-1:0]  o_core_rpt;
  logic              i_core_q, i_core_valid, i_core_done;

  int n_chk = 0;
  int n_fail = 0;
  int go_cnt = 0;

  smp_sched #(.TMO_W(6), .RESP_W(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_key1       (i_key1),
    .i_rpt        (i_rpt),
    .i_req        (i_req),
    .i_seed0      (i_seed0),
    .i_seed1      (i_seed1),
    .i_chx0       (i_chx0),
    .i_chx1       (i_chx1),
    .o_ack        (o_ack),
    .o_resp       (o_resp),
    .o_err        (o_err),
    .o_busy       (o_busy),
    .o_core_go    (o_core_go),
    .o_core_key1  (o_core_key1),
    .o_core_seed  (o_core_seed),
    .o_core_chx   (o_core_chx),
    .o_core_rpt   (o_core_rpt),
    .i_core_q     (i_core_q),
    .i_core_valid (i_core_valid),
    .i_core_done  (i_core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_core_go) go_cnt <= go_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"},  o_ack, 0);
    chk({tag, "_resp"}, o_resp, 0);
    chk({tag, "_err"},  o_err, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_go"},   o_core_go, 0);
    chk({tag, "_seed"}, o_core_seed, 0);
    chk({tag, "_chx"},  o_core_chx, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_go();
    int t = 0;
    while (!o_core_go && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("go_seen", o_core_go, 1);
  endtask

  // Sends n strobes, bits[n-1] first, then a one-cycle done pulse.
  task automatic core_serve(input int n, input logic [63:0] bits);
    for (int i = n - 1; i >= 0; i--) begin
      i_core_valid = 1'b1;
      i_core_q     = bits[i];
      @(negedge clk);
    end
    i_core_valid = 1'b0;
    i_core_q     = 1'b0;
    i_core_done  = 1'b1;
    @(negedge clk);
    i_core_done  = 1'b0;
  endtask

  task automatic wait_ack();
    int t = 0;
    while (o_ack == '0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ack_seen", (o_ack != '0), 1);
  endtask

  initial begin
    int g0;
    logic ack_any;
    rst_n = 1'b0;
    i_key1 = 56'hA5A5_1234_5678_9A; i_rpt = 4'd7;
    i_req = '0;
    i_seed0 = 56'h11_1111_2222_3333; i_seed1 = 56'h44_5555_6666_7777;
    i_chx0 = 8'd4; i_chx1 = 8'd3;
    i_core_q = 0; i_core_valid = 0; i_core_done = 0;
    @(negedge clk);
    do_reset();

    // Single requester, 4 bits 1,0,1,1
    i_req = 2'b01;
    wait_go();
    chk("t1_seed", o_core_seed, 56'h11_1111_2222_3333);
    chk("t1_key1", o_core_key1, 56'hA5A5_1234_5678_9A);
    chk("t1_chx",  o_core_chx, 4);
    chk("t1_rpt",  o_core_rpt, 7);
    core_serve(4, 64'b1011);
    wait_ack();
    chk("t1_ack",  o_ack, 2'b01);
    chk("t1_resp", o_resp, 64'hB);
    chk("t1_err",  o_err, 0);
    i_req = '0;
    @(negedge clk);
    chk("t1_ack_1cyc", o_ack, 0);
    chk("t1_resp_hold", o_resp, 64'hB);
    @(negedge clk);
    chk("t1_busy_idle", o_busy, 0);

    // Both requesting: fresh pointer means 0 then 1
    do_reset();
    i_chx0 = 8'd2; i_chx1 = 8'd3;
    i_req = 2'b11;
    wait_go();
    chk("t2a_seed", o_core_seed, 56'h11_1111_2222_3333);
    chk("t2a_chx",  o_core_chx, 2);
    core_serve(2, 64'b10);
    wait_ack();
    chk("t2a_ack",  o_ack, 2'b01);
    chk("t2a_resp", o_resp, 64'h2);
    chk("t2a_err",  o_err, 0);
    wait_go();
    chk("t2b_seed", o_core_seed, 56'h44_5555_6666_7777);
    chk("t2b_chx",  o_core_chx, 3);
    core_serve(3, 64'b101);
    wait_ack();
    chk("t2b_ack",  o_ack, 2'b10);
    chk("t2b_resp", o_resp, 64'h5);
    chk("t2b_err",  o_err, 0);
    i_req = '0;
    repeat (2) @(negedge clk);

    // Zero challenge count: immediate error response, go never asserted
    i_chx1 = 8'd0;
    g0 = go_cnt;
    i_req = 2'b10;
    @(negedge clk);
    chk("t3_busy", o_busy, 1);
    chk("t3_ack_early", o_ack, 0);
    @(negedge clk);
    chk("t3_ack",  o_ack, 2'b10);
    chk("t3_resp", o_resp, 0);
    chk("t3_err",  o_err, 1);
    i_req = '0;
    repeat (2) @(negedge clk);
    chk("t3_no_go", go_cnt - g0, 0);

    // Watchdog: core never responds, TMO_W=6 -> 63 go cycles
    i_chx0 = 8'd5;
    g0 = go_cnt;
    i_req = 2'b01;
    wait_ack();
    chk("t4_ack",  o_ack, 2'b01);
    chk("t4_err",  o_err, 1);
    chk("t4_resp", o_resp, 0);
    chk("t4_go_cycles", go_cnt - g0, 63);
    i_req = '0;
    repeat (2) @(negedge clk);

    // Short strobe count: 2 of 3
    i_chx0 = 8'd3;
    i_req = 2'b01;
    wait_go();
    core_serve(2, 64'b10);
    wait_ack();
    chk("t5_ack",  o_ack, 2'b01);
    chk("t5_err",  o_err, 1);
    chk("t5_resp", o_resp, 64'h2);
    i_req = '0;
    repeat (2) @(negedge clk);

    // Reset during GO, then a clean transaction
    i_chx0 = 8'd4;
    i_req = 2'b01;
    wait_go();
    i_core_valid = 1'b1; i_core_q = 1'b1;
    @(negedge clk);
    i_core_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_async");
    i_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      ack_any = ack_any | (o_ack != '0);
    end
    chk("t6_no_ack", ack_any, 0);
    i_req = 2'b01;
    wait_go();
    chk("t6_seed", o_core_seed, 56'h11_1111_2222_3333);
    core_serve(4, 64'b0110);
    wait_ack();
    chk("t6_ack",  o_ack, 2'b01);
    chk("t6_resp", o_resp, 64'h6);
    chk("t6_err",  o_err, 0);
    i_req = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/smp_sched.md
SMP_SCHED -- requirements
Module: smp_sched

Interface
REQ-001 Parameter TMO_W, default 20: width of the watchdog counter; timeout occurs at 2^TMO_W-1 cycles in GO.
REQ-002 Parameter RESP_W, default 64: width of the response shift register.
REQ-003 clk  in  1  clock; all logic is rising-edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_key1  in  56  shared device key; sampled at grant.
REQ-006 i_rpt  in  4  shared repeat count; sampled at grant.
REQ-007 i_req  in  2  per-requester request level; held high until that requester's ack.
REQ-008 i_seed0 / i_seed1  in  56 each  challenge seed of requester 0 / 1.
REQ-009 i_chx0 / i_chx1  in  8 each  challenge count of requester 0 / 1.
REQ-010 o_ack  out  2  one-cycle completion pulse, one-hot, to the served requester.
REQ-011 o_resp  out  RESP_W  response word; valid while o_ack is nonzero.
REQ-012 o_err  out  1  error flag for the transaction; valid while o_ack is nonzero.
REQ-013 o_busy  out  1  high in every state except IDLE.
REQ-014 o_core_go, o_core_key1[56], o_core_seed[56], o_core_chx[8], o_core_rpt[4]  out  drive the SMP core.
REQ-015 i_core_q, i_core_valid, i_core_done  in  1 each  SMP core response bit, bit strobe, and completion.

Function
REQ-016 FSM states SHALL be IDLE, ARB, GO, DRAIN and RESP.
REQ-017 IDLE->ARB when i_req!=0 and i_core_done==0; otherwise remain in IDLE.
REQ-018 ARB: round-robin grant. Requester 0 wins if only i_req[0] is set; requester 1 wins if only i_req[1] is set. If both are set, the winner is the one not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-019 ARB: latch the winner's seed and chx, plus i_key1 and i_rpt, into o_core_* registers; clear the response register and the watchdog; clear the error flag.
REQ-020 ARB with latched chx==0: go to RESP with err=1 and resp=0; o_core_go is never asserted.
REQ-021 ARB with latched chx!=0: go to GO; o_core_go rises the cycle after ARB.
REQ-022 GO: hold o_core_go=1. On each cycle with i_core_valid=1, the response register becomes {resp[RESP_W-2:0], i_core_q}, so the last bit is the LSB. Only the most recent RESP_W bits are kept.
REQ-023 GO: count bit strobes with a 9-bit counter. When i_core_done=1, go to DRAIN; err=1 if the strobe count != latched chx.
REQ-024 GO: the watchdog increments every cycle. At all-ones, go to DRAIN with err=1 and resp kept as captured.
REQ-025 DRAIN: o_core_go=0. Wait for i_core_done==0, then go to RESP. Strobes arriving in DRAIN are ignored.
REQ-026 RESP: assert o_ack[grant] for exactly one cycle with o_resp and o_err stable; next state IDLE.
REQ-027 o_resp and o_err SHALL hold their values until the next ARB.
REQ-028 Requests arriving or dropping outside IDLE/ARB are ignored. Latched inputs are unaffected by input changes after ARB.
REQ-029 Minimum gap between consecutive acks is 3 cycles (RESP->IDLE->ARB).

Reset
REQ-030 Asynchronous reset SHALL force: state IDLE, o_ack=0, o_resp=0, o_err=0, o_busy=0, o_core_go=0, o_core_* data=0, counters=0, last-grant pointer=1.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no ack; the core is reset by the same rst_n.

Structure
REQ-032 A shared package smp_pkg SHALL hold the FSM state encoding, the key/seed width constant 56, and the default TMO_W/RESP_W values.
REQ-033 The round-robin 2-way arbiter SHALL be a separate sub-module smp_rr_arb (inputs req, enable; outputs one-hot grant; owns the last-grant pointer).
REQ-034 smp_sched SHALL contain no instance of the SMP core; it connects at the level above.

Verification
REQ-035 i_req=01, chx0=4, core model returns bits 1,0,1,1 -> o_ack=01 for 1 cycle, o_resp=0x...0B, o_err=0.
REQ-036 i_req=11 held for two transactions -> first ack 01, second ack 10, with each requester's own seed on o_core_seed.
REQ-037 i_req=10, chx1=0 -> o_ack=10 two cycles after the request, o_resp=0, o_err=1, o_core_go never high.
REQ-038 TMO_W=6, core never asserts done -> o_core_go drops after 63 GO cycles, o_ack pulses with o_err=1.
REQ-039 chx0=3, core returns only 2 strobes, then done -> o_err=1, o_resp=0x..2 bits captured.
REQ-040 rst_n low during GO -> all outputs return to 0 asynchronously, no ack; a fresh i_req=01 then completes normally.
